vec_stream_serializer: RTL

- Drains the parallel activation vector produced by a MAC engine (output_vec / output_valid pulse) into an element-serial valid/ready stream.
- Feeds downstream consumers: UART/DMA bridge, result FIFO, next-layer loader.
- Captures the whole vector in one cycle into a shadow buffer, so the engine can start its next computation immediately.
- Emits elements in index order 0..VEC_DIM-1 and flags the last one.

---
 rtl/ita_stream_pkg.sv | 11 +
 rtl/vec_stream_serializer.sv | 105 ++++++++++
 2 files changed

// File: rtl/ita_stream_pkg.sv
// Shared definitions for the ITA activation stream serializer/deserializer pair.
package ita_stream_pkg;

    typedef enum logic [0:0] {
        S_IDLE,
        S_STREAM
    } ser_state_t;

    localparam int ACT_BITS_DEFAULT = 8;

endpackage

// File: rtl/vec_stream_serializer.sv
// Captures a parallel activation vector into a shadow buffer and drains it as an
// element-serial valid/ready stream in index order, flagging the last element.
module vec_stream_serializer
    import ita_stream_pkg::*;
#(
    parameter  int VEC_DIM  = 64,
    parameter  int ACT_BITS = ACT_BITS_DEFAULT,
    localparam int IDX_W    = $clog2(VEC_DIM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ACT_BITS-1:0] vec_in [VEC_DIM],
    input  logic                vec_valid,
    output logic                vec_busy,
    output logic [ACT_BITS-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [IDX_W-1:0]    m_index,
    output logic                overrun,
    input  logic                overrun_clr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_DIM - 1);

    ser_state_t          state;
    ser_state_t          next_state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    next_idx;
    logic [ACT_BITS-1:0] shadow [VEC_DIM];
    logic                capture;
    logic                drop;
    logic                fire;
    logic                at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
            // a drop in the same cycle as a clear must leave the flag set
            if (drop)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int unsigned k = 0; k < VEC_DIM; k++)
                shadow[k] <= vec_in[k];
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = idx;
        capture    = 1'b0;
        drop       = 1'b0;
        at_last    = (idx == LAST_IDX);
        fire       = (state == S_STREAM) && m_ready;

        case (state)
            S_IDLE: begin
                if (vec_valid) begin
                    capture    = 1'b1;
                    next_state = S_STREAM;
                    next_idx   = '0;
                end
            end
            S_STREAM: begin
                if (fire) begin
                    if (at_last) begin
                        next_idx = '0;
                        if (vec_valid)
                            capture = 1'b1;
                        else
                            next_state = S_IDLE;
                    end else begin
                        next_idx = idx + IDX_W'(1);
                    end
                end
                // only a final-beat handshake frees the buffer for a new vector
                drop = vec_valid && !capture;
            end
            default: begin
                next_state = S_IDLE;
                next_idx   = '0;
            end
        endcase
    end

    always_comb begin
        vec_busy = (state == S_STREAM);
        m_valid  = (state == S_STREAM);
        m_data   = m_valid ? shadow[idx] : '0;
        m_last   = m_valid && at_last;
        m_index  = idx;
    end

endmodule
